uart_rx_fifo_ctrl: RTL

- Parametrised UART receive FIFO with integrated storage, byte-level read handshake, level-threshold interrupt, sticky overrun flag and character-timeout detection.
- Sits between the RX deserializer (write side) and the CPU/bus register interface (read side).
- Successor to the fixed 32-entry pointer-only RX FIFO controller.
- Supports simultaneous read and write, exact occupancy count, per-entry error tagging, and flush.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fifo_ctrl_if.sv | 31 +++
 rtl/rx_fifo_mem.sv | 22 ++
 rtl/uart_rx_fifo_ctrl.sv | 58 +++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults, RX entry type and log2 helper for the UART RX FIFO
package uart_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_TO_CYC = 4096;
  typedef struct packed {
    logic                  err;
    logic [DEF_DATA_W-1:0] data;
  } rx_entry_t;
  function automatic int log2c(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_rx_fifo_ctrl_if.sv
// uart_rx_fifo_ctrl_if: deserializer write side, CPU read side and status of the RX FIFO
interface uart_rx_fifo_ctrl_if import uart_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);
  localparam int ADDR_W = log2c(DEPTH);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_err;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;
  logic              rd_valid;
  logic              flush;
  logic              ovr_clr;
  logic [ADDR_W:0]   rx_thresh;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              overrun;
  logic              level_irq;
  logic              timeout;
  modport master (
    output wr_en, wr_data, wr_err, rd_en, flush, ovr_clr, rx_thresh,
    input  rd_data, rd_err, rd_valid, count, empty, full, overrun, level_irq, timeout
  );
  modport slave (
    input  wr_en, wr_data, wr_err, rd_en, flush, ovr_clr, rx_thresh,
    output rd_data, rd_err, rd_valid, count, empty, full, overrun, level_irq, timeout
  );
endinterface

// File: rtl/rx_fifo_mem.sv
// rx_fifo_mem: simple dual-port RAM with one write port and a registered read port
module rx_fifo_mem #(
  parameter int W     = 9,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// uart_rx_fifo_ctrl: UART RX FIFO with occupancy, level irq, sticky overrun and char timeout
module uart_rx_fifo_ctrl import uart_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TO_CYC = DEF_TO_CYC
) (
  input logic               clk,
  input logic               rst,
  uart_rx_fifo_ctrl_if.slave bus
);
  localparam int ADDR_W = log2c(DEPTH);
  localparam int TO_W   = log2c(TO_CYC + 1);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W:0]   rd_q;
  logic              wr_acc, rd_acc, drop;
  always_comb begin
    wr_acc    = bus.wr_en & ~bus.full & ~bus.flush;
    rd_acc    = bus.rd_en & ~bus.empty & ~bus.flush;
    drop      = bus.wr_en & bus.full & ~bus.flush;
    count_nxt = bus.flush ? '0 : bus.count + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
  end
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      bus.count    <= '0;
      bus.empty    <= 1'b1;
      bus.full     <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.overrun  <= 1'b0;
      to_cnt       <= '0;
    end else begin
      wr_ptr       <= bus.flush ? '0 : wr_ptr + ADDR_W'(wr_acc);
      rd_ptr       <= bus.flush ? '0 : rd_ptr + ADDR_W'(rd_acc);
      bus.count    <= count_nxt;
      bus.empty    <= count_nxt == '0;
      bus.full     <= count_nxt == (ADDR_W+1)'(DEPTH);
      bus.rd_valid <= rd_acc;
      bus.overrun  <= drop | (bus.overrun & ~bus.ovr_clr);
      to_cnt       <= (bus.flush | wr_acc | rd_acc | bus.empty) ? '0
                    : to_cnt + TO_W'(to_cnt != TO_W'(TO_CYC));
    end
  assign bus.level_irq = (bus.rx_thresh != '0) && (bus.count >= bus.rx_thresh);
  assign bus.timeout   = to_cnt == TO_W'(TO_CYC);
  assign {bus.rd_err, bus.rd_data} = rd_q;
  rx_fifo_mem #(.W(DATA_W + 1), .DEPTH(DEPTH), .AW(ADDR_W)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata ({bus.wr_err, bus.wr_data}),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (rd_q)
  );
endmodule
